// File: rtl/timer_pkg.sv
// Shared constants and types for the DIV/TIMA/TMA/TAC timer.
// Holds the register map, FSM states, TAC tap table and TAC read mask.
package timer_pkg;

    localparam logic [1:0] A_DIV  = 2'd0;
    localparam logic [1:0] A_TIMA = 2'd1;
    localparam logic [1:0] A_TMA  = 2'd2;
    localparam logic [1:0] A_TAC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RELOAD = 2'd2
    } tstate_e;

    // Divider bit watched for each TAC[1:0] setting.
    localparam logic [3:0] TAP_IDX [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

    localparam logic [7:0] TAC_RD_MASK = 8'hF8;

    function automatic logic tap_bit(
        input logic [9:0] lo,
        input logic [1:0] sel
    );
        return lo[TAP_IDX[sel]];
    endfunction

    function automatic logic [7:0] tac_rd(input logic [2:0] tac);
        return TAC_RD_MASK | {5'b00000, tac};
    endfunction

endpackage

// File: rtl/dmg_timer_div.sv
// Free-running divider with clear-on-write, TAC tap mux and falling-edge detector.
// Ports: clk_i/rst_i, clr_i (DIV write), tac_i/tac_wr_i (TAC value and write
// strobe), inc_pulse_o (TIMA tick), sixteen_hz_o (divider MSB), div_o (cnt[15:8]).
// Macro TIMER_GLITCH_EN: edge detector sees the enable-gated tap.
module dmg_timer_div
    import timer_pkg::*;
#(
    parameter int CNT_W = 18
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       tac_wr_i,
    input  logic [2:0] tac_i,
    output logic       inc_pulse_o,
    output logic       sixteen_hz_o,
    output logic [7:0] div_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_bit;
    logic             tap;
    logic             tap_q;

    assign cnt_d        = clr_i ? '0 : cnt_q + CNT_W'(1);
    assign sel_bit      = tap_bit(cnt_q[9:0], tac_i[1:0]);
    assign sixteen_hz_o = cnt_q[CNT_W-1];
    assign div_o        = cnt_q[15:8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tap_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tap_q <= tap;
        end
    end

`ifdef TIMER_GLITCH_EN
    // Gating before the edge detector lets DIV/TAC writes produce a tick.
    logic unused_tac_wr;
    assign unused_tac_wr = tac_wr_i;
    assign tap           = sel_bit & tac_i[2];
    assign inc_pulse_o   = tap_q & ~tap;
`else
    // The ungated bit is tracked; a fall caused by a DIV or TAC write in the
    // previous cycle is masked so software writes never tick TIMA.
    logic sup_q;
    assign tap         = sel_bit;
    assign inc_pulse_o = tap_q & ~tap & tac_i[2] & ~sup_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sup_q <= 1'b0;
        end else begin
            sup_q <= clr_i | tac_wr_i;
        end
    end
`endif

endmodule

// File: rtl/dmg_timer.sv
// DIV/TIMA/TMA/TAC timer: bus decode, TIMA/TMA/TAC registers and reload FSM.
// Ports: CLK, RESET (async high), ADDR/WR/DIN write bus, DOUT comb read,
// TIMER_IRQ one-cycle reload pulse, SIXTEEN_HZ divider MSB.
// Macro TIMER_GLITCH_EN (in dmg_timer_div) selects glitch-accurate ticking.
module dmg_timer
    import timer_pkg::*;
#(
    parameter int CNT_W    = 18,
    parameter int PEND_CYC = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] ADDR,
    input  logic       WR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       TIMER_IRQ,
    output logic       SIXTEEN_HZ
);

    localparam logic [7:0] PEND_LAST = 8'(PEND_CYC - 2);

    tstate_e    state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic [7:0] div_val;
    logic [7:0] reload_v;
    logic       inc;
    logic       wr_div, wr_tima, wr_tma, wr_tac;

    assign wr_div  = WR & (ADDR == A_DIV);
    assign wr_tima = WR & (ADDR == A_TIMA);
    assign wr_tma  = WR & (ADDR == A_TMA);
    assign wr_tac  = WR & (ADDR == A_TAC);

    dmg_timer_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clr_i       (wr_div),
        .tac_wr_i    (wr_tac),
        .tac_i       (tac_q),
        .inc_pulse_o (inc),
        .sixteen_hz_o(SIXTEEN_HZ),
        .div_o       (div_val)
    );

    // A TMA write in the reload cycle is forwarded straight into TIMA.
    assign reload_v = wr_tma ? DIN : tma_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pend_q  <= '0;
            tima_q  <= '0;
            tma_q   <= '0;
            tac_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tima_d  = tima_q;
        tma_d   = wr_tma ? DIN : tma_q;
        tac_d   = wr_tac ? DIN[2:0] : tac_q;
        unique case (state_q)
            IDLE: begin
                if (wr_tima) begin
                    tima_d = DIN;
                end else if (inc) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = PEND;
                        pend_d  = '0;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            PEND: begin
                if (wr_tima) begin
                    tima_d  = DIN;
                    state_d = IDLE;
                end else if (pend_q == PEND_LAST) begin
                    tima_d  = reload_v;
                    state_d = RELOAD;
                end else begin
                    pend_d = pend_q + 8'd1;
                    if (inc) begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            RELOAD: begin
                // TIMA writes lose here; a tick lands on the reload value.
                if (inc && (reload_v == 8'hFF)) begin
                    tima_d  = 8'h00;
                    state_d = PEND;
                    pend_d  = '0;
                end else begin
                    tima_d  = reload_v + {7'b0000000, inc};
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign TIMER_IRQ = (state_q == RELOAD);

    always_comb begin
        DOUT = 8'h00;
        unique case (ADDR)
            A_DIV:  DOUT = div_val;
            A_TIMA: DOUT = tima_q;
            A_TMA:  DOUT = tma_q;
            A_TAC:  DOUT = tac_rd(tac_q);
        endcase
    end

endmodule
